instr_loader: RTL
=================

// Module: instr_loader
// PURPOSE
//  Program loader: writer side of the instruction memory. Accepts a stream of
//  machine-code words over a valid/ready handshake and writes them to
//  consecutive instruction-memory addresses starting at 0. Sits between the
//  host/testbench program source and the instruction RAM write port. Done gates
//  the CPU out of reset once the image is resident.
// PARAMETERS
//  AW     12          address width; memory depth = 2**AW words
//  DW     9           instruction word width
// PORTS
//  Clk        in   1    clock; all state changes on posedge
//  Reset      in   1    synchronous, active-high reset
//  Start      in   1    begin a load; sampled in IDLE, DONE, ERROR only
//  InValid    in   1    InData/InLast valid this cycle
//  InData     in   DW   instruction word
//  InLast     in   1    marks final word of the image
//  InReady    out  1    loader accepts a word this cycle
//  WrEn       out  1    instruction-memory write strobe, one cycle per word
//  WrAddr     out  AW   write address
//  WrData     out  DW   write data
//  Busy       out  1    FSM in LOAD
//  Done       out  1    image loaded; held until next Start or Reset
//  Overflow   out  1    image exceeded 2**AW words; held until Start or Reset
//  WordCount  out  AW+1 words accepted in current/last load
//  Checksum   out  DW   sum of accepted words, mod 2**DW
// BEHAVIOUR
//  - Reset: FSM=IDLE; InReady, WrEn, Busy, Done, Overflow=0; WrAddr, WrData,
//    WordCount, Checksum=0. Reset mid-load aborts the load; a pending write is
//    dropped (WrEn=0 after the reset edge). Reset has priority over all inputs.
//  - States: IDLE, LOAD, DONE, ERROR.
//    IDLE  -Start-> LOAD.  DONE/ERROR -Start-> LOAD.  LOAD ignores Start.
//    Entering LOAD clears WordCount, Checksum, Done, Overflow; next addr = 0.
//  - InReady = (state==LOAD); combinational from state only, never from InValid.
//  - Accept = InValid & InReady. On accept at cycle N: at N+1 WrEn=1,
//    WrAddr=addr, WrData=InData (registered, 1-cycle latency); addr increments;
//    WordCount += 1; Checksum += InData (wraps mod 2**DW).
//  - WrEn is 0 in every cycle not following an accept. WrAddr/WrData hold
//    their last value when WrEn=0.
//  - Accept with InLast=1 -> DONE (that word is still written at N+1).
//  - Accept with InLast=0 at addr 2**AW-1 -> word written, then ERROR,
//    Overflow=1; addr does not wrap and no further words are accepted.
//  - Accept with InLast=1 at addr 2**AW-1 -> DONE (exactly full is legal).
//  - InValid without InReady: no effect; source must hold data (no drop).
//  - Busy=1 iff LOAD; Done=1 iff DONE; Overflow=1 iff ERROR.
//  - Start and accept in the same cycle in DONE/ERROR: Start wins, InReady=0
//    that cycle, so no word is taken.
// TESTING
//  1 Start; send 0x1A5,0x003,0x0FF(last) back-to-back -> WrEn at 3 cycles,
//    addr 0,1,2 data as sent; Done=1; WordCount=3; Checksum=0x0A7.
//  2 Same image with InValid gaps of 0-3 cycles -> identical writes/Checksum;
//    WrEn never asserted in gap cycles.
//  3 AW=3: send 9 words, none last -> 8 writes (addr 0-7), Overflow=1,
//    InReady=0, 9th word never written; AW=3 with last on 8th -> Done=1.
//  4 Reset asserted after 2nd accept of 5-word load -> all outputs 0 next
//    cycle, no write for the in-flight word, FSM IDLE.
//  5 After Done, Start then 2-word image 0x001,0x002(last) -> Done drops,
//    writes at addr 0,1, WordCount=2, Checksum=0x003, Done=1 again.
//  6 InValid=1 in IDLE without Start for 10 cycles -> InReady=0, WrEn=0,
//    WordCount=0.

Source files
------------

// File: rtl/instr_loader.sv
// Program loader: streams machine-code words from a valid/ready source
// into consecutive instruction-memory addresses starting at zero.
module instr_loader #(
  parameter int AW = 12,
  parameter int DW = 9
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          InValid,
  input  logic [DW-1:0] InData,
  input  logic          InLast,
  output logic          InReady,
  output logic          WrEn,
  output logic [AW-1:0] WrAddr,
  output logic [DW-1:0] WrData,
  output logic          Busy,
  output logic          Done,
  output logic          Overflow,
  output logic [AW:0]   WordCount,
  output logic [DW-1:0] Checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  state_t state;
  state_t nxt;

  logic [AW-1:0] addr;
  logic          accept;
  logic          at_end;
  logic          start_ok;

  assign accept   = InValid & InReady;
  assign at_end   = (addr == {AW{1'b1}});
  assign start_ok = Start & (state != S_LOAD);

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) nxt = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          if (InLast)      nxt = S_DONE;
          else if (at_end) nxt = S_ERR;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    InReady  = (state == S_LOAD);
    Busy     = (state == S_LOAD);
    Done     = (state == S_DONE);
    Overflow = (state == S_ERR);
  end

  // Address holds at the top word so an overflow never wraps onto word 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr      <= '0;
      WrEn      <= 1'b0;
      WrAddr    <= '0;
      WrData    <= '0;
      WordCount <= '0;
      Checksum  <= '0;
    end else begin
      WrEn <= accept;
      if (accept) begin
        WrAddr    <= addr;
        WrData    <= InData;
        WordCount <= WordCount + (AW+1)'(1);
        Checksum  <= Checksum + InData;
        if (!at_end) addr <= addr + AW'(1);
      end else if (start_ok) begin
        addr      <= '0;
        WordCount <= '0;
        Checksum  <= '0;
      end
    end
  end

endmodule
